mic_delay_sum: RTL and testbench

Per-channel delay-and-sum stage for the four-microphone array. Sits between the two I2S receivers (four 16-bit mic samples per I2S frame) and the I2S transmitter. Writes each frame's four samples into a block-RAM delay line, reads back one delayed sample per mic using per-channel tap delays, and emits the four delayed samples plus their scaled sum for the DAC path. Runs in the system clock domain; one frame strobe per I2S frame.

---
 rtl/mems_pkg.sv | 27 ++
 rtl/delay_ram.sv | 21 ++
 rtl/mic_delay_sum.sv | 168 ++++++++++++++++
 tb/tb_mic_delay_sum.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mems_pkg.sv
// Shared constants, FSM state encoding and RAM address helper for the
// four-microphone delay-and-sum path.
package mems_pkg;
    localparam int N_MICS        = 4;
    localparam int WIDTH_DEF     = 16;
    localparam int ADDR_BITS_DEF = 8;
    localparam int ADDR_BITS_MAX = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_FLUSH,
        S_DONE
    } state_t;

    // Channel index occupies the bits directly above the per-channel pointer.
    function automatic logic [ADDR_BITS_MAX+1:0] ram_addr(
        input logic [1:0]               ch,
        input logic [ADDR_BITS_MAX-1:0] ptr,
        input int                       abits
    );
        logic [ADDR_BITS_MAX+1:0] a;
        a = {{ADDR_BITS_MAX{1'b0}}, ch} << abits;
        return a | {2'b00, ptr};
    endfunction
endpackage

// File: rtl/delay_ram.sv
// Simple dual-port delay-line RAM: synchronous write, registered read,
// no reset on the array so it maps onto block RAM.
module delay_ram #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [0:(1<<DEPTH_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mic_delay_sum.sv
// Per-channel delay-and-sum: each frame is written to a shared delay line,
// one tap per mic is read back, and the four taps plus their quarter-sum are emitted.
module mic_delay_sum
    import mems_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 strobe,
    input  logic [WIDTH-1:0]     mic_0,
    input  logic [WIDTH-1:0]     mic_1,
    input  logic [WIDTH-1:0]     mic_2,
    input  logic [WIDTH-1:0]     mic_3,
    input  logic [ADDR_BITS-1:0] delay_0,
    input  logic [ADDR_BITS-1:0] delay_1,
    input  logic [ADDR_BITS-1:0] delay_2,
    input  logic [ADDR_BITS-1:0] delay_3,
    output logic [WIDTH-1:0]     out_0,
    output logic [WIDTH-1:0]     out_1,
    output logic [WIDTH-1:0]     out_2,
    output logic [WIDTH-1:0]     out_3,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output state_t               dbg_state
);
    localparam int ADDR_W = ADDR_BITS + 2;

    state_t               state_q, state_n;
    logic [1:0]           ch_q, ch_n;
    logic [ADDR_BITS-1:0] wptr, filled;
    logic [WIDTH-1:0]     in_mic    [N_MICS];
    logic [ADDR_BITS-1:0] in_delay  [N_MICS];
    logic [WIDTH-1:0]     cap_mic   [N_MICS];
    logic [ADDR_BITS-1:0] cap_delay [N_MICS];
    logic [WIDTH-1:0]     stage     [N_MICS];
    logic [WIDTH-1:0]     fin       [N_MICS];
    logic [WIDTH-1:0]     out_q     [N_MICS];
    logic [WIDTH-1:0]     out_sum_q;
    logic                 out_valid_q, overrun_q;
    logic                 rd_pend, rd_zero;
    logic [1:0]           rd_ch;

    logic [ADDR_BITS-1:0] tap_delay, rd_ptr;
    logic                 primed, we, re;
    logic [ADDR_W-1:0]    waddr, raddr;
    logic [WIDTH-1:0]     rdata, rd_value;
    logic signed [WIDTH+1:0] sum_full;

    assign in_mic   = '{mic_0, mic_1, mic_2, mic_3};
    assign in_delay = '{delay_0, delay_1, delay_2, delay_3};

    // A tap reaching further back than the frames written since reset reads as 0.
    assign tap_delay = cap_delay[ch_q];
    assign primed    = (tap_delay <= filled);
    assign rd_ptr    = wptr - tap_delay;
    assign we        = (state_q == S_WR);
    assign re        = (state_q == S_RD) && primed;
    assign waddr     = ADDR_W'(ram_addr(ch_q, ADDR_BITS_MAX'(wptr), ADDR_BITS));
    assign raddr     = ADDR_W'(ram_addr(ch_q, ADDR_BITS_MAX'(rd_ptr), ADDR_BITS));
    assign rd_value  = rd_zero ? '0 : rdata;

    delay_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (cap_mic[ch_q]),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state_q;
        ch_n    = ch_q;
        case (state_q)
            S_IDLE: if (strobe) begin
                state_n = S_WR;
                ch_n    = 2'd0;
            end
            S_WR: begin
                ch_n = ch_q + 2'd1;
                if (ch_q == 2'd3) state_n = S_RD;
            end
            S_RD: begin
                ch_n = ch_q + 2'd1;
                if (ch_q == 2'd3) state_n = S_FLUSH;
            end
            S_FLUSH: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Channel 3's tap is still arriving from the RAM during FLUSH.
    always_comb begin
        for (int k = 0; k < N_MICS; k++) fin[k] = stage[k];
        fin[N_MICS-1] = rd_value;
        sum_full = '0;
        for (int k = 0; k < N_MICS; k++)
            sum_full = sum_full + (WIDTH+2)'($signed(fin[k]));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= 2'd0;
        end else begin
            state_q <= state_n;
            ch_q    <= ch_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && strobe) begin
            cap_mic   <= in_mic;
            cap_delay <= in_delay;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wptr        <= '0;
            filled      <= '0;
            rd_pend     <= 1'b0;
            rd_zero     <= 1'b0;
            rd_ch       <= 2'd0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < N_MICS; k++) begin
                stage[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            rd_pend     <= (state_q == S_RD);
            rd_zero     <= !primed;
            rd_ch       <= ch_q;
            out_valid_q <= (state_q == S_FLUSH);
            if (rd_pend) stage[rd_ch] <= rd_value;
            if (state_q == S_FLUSH) begin
                out_q     <= fin;
                out_sum_q <= sum_full[WIDTH+1:2];
            end
            if (state_q == S_DONE) begin
                wptr <= wptr + 1'b1;
                if (filled != '1) filled <= filled + 1'b1;
            end
            if (strobe && state_q != S_IDLE) overrun_q <= 1'b1;
        end
    end

    assign out_0     = out_q[0];
    assign out_1     = out_q[1];
    assign out_2     = out_q[2];
    assign out_3     = out_q[3];
    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mic_delay_sum.sv
// Randomized bench for mic_delay_sum against a frame-history reference model.
module tb_mic_delay_sum;
    import mems_pkg::*;

    logic        clk = 1'b0;
    logic        rst, strobe;
    logic [15:0] mic_0, mic_1, mic_2, mic_3;
    logic [7:0]  delay_0, delay_1, delay_2, delay_3;
    logic [15:0] out_0, out_1, out_2, out_3, out_sum;
    logic        out_valid, busy, overrun;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] hist[$];
    logic [79:0] exp_q[$];
    logic [79:0] obs_out, exp_v;
    int          obs_valid_at, obs_valid_cnt;
    logic        obs_busy_ok;

    mic_delay_sum dut (
        .CLK(clk), .rst(rst), .strobe(strobe),
        .mic_0(mic_0), .mic_1(mic_1), .mic_2(mic_2), .mic_3(mic_3),
        .delay_0(delay_0), .delay_1(delay_1), .delay_2(delay_2), .delay_3(delay_3),
        .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
        .out_sum(out_sum), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: output tap = sample from d frames ago, or 0 if fewer frames exist since reset.
    task automatic model_frame(input logic [63:0] m, input logic [31:0] d);
        int f, s, dk;
        logic [15:0] o[4];
        logic [15:0] sv;
        hist.push_back(m);
        f = hist.size() - 1;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            dk = int'(d[8*k +: 8]);
            o[k] = (dk <= f) ? hist[f-dk][16*k +: 16] : 16'h0;
            s = s + int'($signed(o[k]));
        end
        sv = 16'(s >>> 2);
        exp_q.push_back({sv, o[3], o[2], o[1], o[0]});
    endtask

    task automatic drive_inputs(input logic [63:0] m, input logic [31:0] d);
        {mic_3, mic_2, mic_1, mic_0}         = m;
        {delay_3, delay_2, delay_1, delay_0} = d;
    endtask

    // Called in cycle T (just after an edge); returns in cycle T+11.
    task automatic send_frame(input logic [63:0] m, input logic [31:0] d);
        strobe = 1'b1;
        drive_inputs(m, d);
        obs_valid_at = -1; obs_valid_cnt = 0; obs_busy_ok = 1'b1; obs_out = '0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                strobe = 1'b0;
                drive_inputs({$urandom, $urandom}, $urandom);
            end
            if (busy !== (c <= 10)) obs_busy_ok = 1'b0;
            if (out_valid === 1'b1) begin
                obs_valid_cnt++;
                if (obs_valid_at < 0) begin
                    obs_valid_at = c;
                    obs_out = {out_sum, out_3, out_2, out_1, out_0};
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if ({out_sum, out_3, out_2, out_1, out_0} !== 80'h0) begin
            n_errors++; $display("FAIL reset_outs got=%h exp=0", {out_sum, out_3, out_2, out_1, out_0}); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_delay0();
        apply_reset();
        model_frame({16'd4, 16'd3, 16'd2, 16'd1}, 32'h0);
        send_frame({16'd4, 16'd3, 16'd2, 16'd1}, 32'h0);
        exp_v = exp_q.pop_front();
        n_checks++; if (obs_out !== {16'd2, 16'd4, 16'd3, 16'd2, 16'd1}) begin
            n_errors++; $display("FAIL delay0_const got=%h exp=%h", obs_out, {16'd2, 16'd4, 16'd3, 16'd2, 16'd1}); end
        n_checks++; if (obs_out !== exp_v) begin n_errors++; $display("FAIL delay0_model got=%h exp=%h", obs_out, exp_v); end
        n_checks++; if (obs_valid_at !== 10) begin n_errors++; $display("FAIL delay0_latency got=%0d exp=10", obs_valid_at); end
        n_checks++; if (obs_valid_cnt !== 1) begin n_errors++; $display("FAIL delay0_valid_cnt got=%0d exp=1", obs_valid_cnt); end
        n_checks++; if (obs_busy_ok !== 1'b1) begin n_errors++; $display("FAIL delay0_busy got=%b exp=1", obs_busy_ok); end
    endtask

    task automatic test_reset_mid_frame();
        int vcnt;
        apply_reset();
        strobe = 1'b1;
        drive_inputs({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            strobe = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) vcnt++;
            @(posedge clk); #1;
        end
        n_checks++; if (vcnt !== 0) begin n_errors++; $display("FAIL midrst_valid got=%0d exp=0", vcnt); end
        n_checks++; if ({out_sum, out_3, out_2, out_1, out_0} !== 80'h0) begin
            n_errors++; $display("FAIL midrst_outs got=%h exp=0", {out_sum, out_3, out_2, out_1, out_0}); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        hist.delete(); exp_q.delete();
        model_frame({16'd40, 16'd30, 16'd20, 16'd10}, {8'd1, 8'd0, 8'd1, 8'd0});
        send_frame({16'd40, 16'd30, 16'd20, 16'd10}, {8'd1, 8'd0, 8'd1, 8'd0});
        exp_v = exp_q.pop_front();
        n_checks++; if (obs_out !== exp_v) begin n_errors++; $display("FAIL midrst_first got=%h exp=%h", obs_out, exp_v); end
        n_checks++; if (obs_out[31:16] !== 16'd0) begin n_errors++; $display("FAIL midrst_primed got=%h exp=0", obs_out[31:16]); end
    endtask

    task automatic test_priming();
        logic [15:0] want1;
        apply_reset();
        for (int n = 0; n < 8; n++) begin
            model_frame({4{16'(n)}}, {8'd0, 8'd0, 8'd3, 8'd0});
            send_frame({4{16'(n)}}, {8'd0, 8'd0, 8'd3, 8'd0});
            exp_v = exp_q.pop_front();
            want1 = (n < 3) ? 16'd0 : 16'(n - 3);
            n_checks++; if (obs_out !== exp_v) begin n_errors++; $display("FAIL prime_model n=%0d got=%h exp=%h", n, obs_out, exp_v); end
            n_checks++; if (obs_out[31:16] !== want1 || obs_out[15:0] !== 16'(n)) begin
                n_errors++; $display("FAIL prime_taps n=%0d got=%h/%h exp=%h/%h", n, obs_out[31:16], obs_out[15:0], want1, 16'(n)); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want;
        int bad;
        apply_reset();
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            model_frame({4{16'(n)}}, {4{8'd255}});
            send_frame({4{16'(n)}}, {4{8'd255}});
            exp_v = exp_q.pop_front();
            want = (n < 255) ? 16'd0 : 16'(n - 255);
            n_checks++; if (obs_out !== exp_v || obs_out[63:0] !== {4{want}} || obs_valid_at !== 10) begin
                n_errors++; bad++;
                if (bad < 10) $display("FAIL wrap n=%0d got=%h exp=%h at=%0d", n, obs_out, exp_v, obs_valid_at);
            end
        end
    endtask

    task automatic test_sum();
        logic [63:0] m [3];
        logic [15:0] want [3];
        m[0] = {4{16'h7FFF}};                        want[0] = 16'h7FFF;
        m[1] = {4{16'h8000}};                        want[1] = 16'h8000;
        m[2] = {16'h0, 16'h0, 16'h8000, 16'h7FFF};   want[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            model_frame(m[i], 32'h0);
            send_frame(m[i], 32'h0);
            exp_v = exp_q.pop_front();
            n_checks++; if (obs_out[79:64] !== want[i]) begin
                n_errors++; $display("FAIL sum_const i=%0d got=%h exp=%h", i, obs_out[79:64], want[i]); end
            n_checks++; if (obs_out !== exp_v) begin n_errors++; $display("FAIL sum_model i=%0d got=%h exp=%h", i, obs_out, exp_v); end
        end
    endtask

    task automatic test_overrun();
        logic [63:0] m1;
        apply_reset();
        m1 = {16'd8, 16'd7, 16'd6, 16'd5};
        model_frame(m1, 32'h0);
        strobe = 1'b1; drive_inputs(m1, 32'h0);
        obs_valid_at = -1; obs_out = '0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            strobe = (c == 5);
            if (c == 5) drive_inputs({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, 32'h0);
            if (out_valid === 1'b1 && obs_valid_at < 0) begin
                obs_valid_at = c; obs_out = {out_sum, out_3, out_2, out_1, out_0};
            end
        end
        exp_v = exp_q.pop_front();
        n_checks++; if (obs_out !== exp_v) begin n_errors++; $display("FAIL ovr_first got=%h exp=%h", obs_out, exp_v); end
        n_checks++; if (obs_valid_at !== 10) begin n_errors++; $display("FAIL ovr_latency got=%0d exp=10", obs_valid_at); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        model_frame({16'd4, 16'd3, 16'd2, 16'd1}, {8'd1, 8'd0, 8'd1, 8'd0});
        send_frame({16'd4, 16'd3, 16'd2, 16'd1}, {8'd1, 8'd0, 8'd1, 8'd0});
        exp_v = exp_q.pop_front();
        n_checks++; if (obs_out !== exp_v || obs_valid_at !== 10) begin
            n_errors++; $display("FAIL ovr_next got=%h at=%0d exp=%h at=10", obs_out, obs_valid_at, exp_v); end
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        apply_reset();
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_random();
        logic [63:0] m;
        logic [31:0] d;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            m = {$urandom, $urandom};
            for (int k = 0; k < 4; k++)
                d[8*k +: 8] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            model_frame(m, d);
            send_frame(m, d);
            exp_v = exp_q.pop_front();
            n_checks++; if (obs_out !== exp_v || obs_valid_cnt !== 1 || obs_busy_ok !== 1'b1) begin
                n_errors++; $display("FAIL rand n=%0d got=%h exp=%h vcnt=%0d busy_ok=%b", n, obs_out, exp_v, obs_valid_cnt, obs_busy_ok);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0;
        drive_inputs('0, '0);
        @(posedge clk); #1;
        test_reset();
        test_delay0();
        test_reset_mid_frame();
        test_priming();
        test_sum();
        test_overrun();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
